// File: rtl/uart_rx_packer_pkg.sv
// Shared types and constants for the UART RX byte packer.
// UART_PACK_DELIM_EN (see uart_rx_packer.sv) is the optional feature macro.
package uart_rx_packer_pkg;

  // Mailbox constants mirrored locally so this slice builds on its own.
  localparam int         NODE_ID_WIDTH = 16;
  localparam logic [3:0] OPC_DATA      = 4'h1;

  // One output beat as held in the output register.
  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  nbytes;
    logic        eop;
  } uart_pack_word_t;

  // Accumulator occupancy; FULL means the word is closed and awaits the output register.
  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FULL
  } uart_pack_state_e;

endpackage

// File: rtl/uart_rx_packer_if.sv
// Mailbox stream endpoint bundle carried from the packer to the endpoint TX port.
interface uart_rx_packer_if;
  import uart_rx_packer_pkg::*;

  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_data;
  logic [2:0]               out_nbytes;
  logic                     out_eop;
  logic [NODE_ID_WIDTH-1:0] out_dest_id;
  logic [3:0]               out_opcode;
  logic                     out_prio;

  modport master (
    output out_valid, out_data, out_nbytes, out_eop, out_dest_id, out_opcode, out_prio,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_nbytes, out_eop, out_dest_id, out_opcode, out_prio,
    output out_ready
  );

endinterface

// File: rtl/uart_rx_packer_idle_timer.sv
// Line-idle timer: counts while run is high, saturates at TIMEOUT_CYCLES-1
// and holds fire there until cleared, so a flush blocked by backpressure is not lost.
module uart_idle_timer #(
  parameter int TIMEOUT_CYCLES = 2170
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic fire
);

  localparam int             W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Count idle cycles; restart on a new byte or when nothing is pending.
  always_ff @(posedge clk) begin
    if (rst || clear || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign fire = run && (count == LAST);

endmodule

// File: rtl/uart_rx_packer.sv
// Packs UART RX bytes little-endian into 32-bit mailbox beats, groups up to
// MSG_WORDS beats per message and flushes on line-idle timeout.
// Optional macro UART_PACK_DELIM_EN adds a delimiter byte that ends a message.
module uart_rx_packer
  import uart_rx_packer_pkg::*;
#(
  parameter int                       MSG_WORDS      = 4,
  parameter int                       TIMEOUT_CYCLES = 2170,
  parameter logic [NODE_ID_WIDTH-1:0] DEFAULT_DEST   = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_byte,
  output logic                     in_ready,
  input  logic                     cfg_enable,
  input  logic [NODE_ID_WIDTH-1:0] cfg_dest,
`ifdef UART_PACK_DELIM_EN
  input  logic                     cfg_delim_en,
  input  logic [7:0]               cfg_delim,
`endif
  uart_rx_packer_if.master         mbx,
  output logic [15:0]              ovf_cnt
);

  localparam int             BW        = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(MSG_WORDS - 1);

  uart_pack_state_e          state_q, state_n;
  logic [2:0]                acc_cnt_q, acc_cnt_n;
  logic [31:0]               acc_data_q, acc_data_n;
  logic                      acc_eop_q, acc_eop_n;
  logic [BW-1:0]             beat_q, beat_n;
  uart_pack_word_t           word_q, word_n;
  logic                      valid_q, valid_n;
  logic [NODE_ID_WIDTH-1:0]  dest_q, dest_n;
  logic [15:0]               ovf_q, ovf_n;

  logic reg_free, is_full, fire, timeout, timer_run;
  logic commit_word, commit_term, accept, drop, eop_now, delim_hit;

`ifdef UART_PACK_DELIM_EN
  assign delim_hit = cfg_delim_en && (in_byte == cfg_delim);
`else
  assign delim_hit = 1'b0;
`endif

  assign timer_run = (acc_cnt_q != 3'd0) || (beat_q != '0);

  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .run  (timer_run),
    .fire (fire)
  );

  // Next-state logic: accumulator FSM, output register, beat counter and overflow count.
  always_comb begin
    reg_free    = !valid_q || mbx.out_ready;
    is_full     = (state_q == FULL);
    timeout     = fire && !in_valid;
    commit_word = reg_free && (is_full || (timeout && (acc_cnt_q != 3'd0)));
    commit_term = reg_free && timeout && (acc_cnt_q == 3'd0) && (beat_q != '0);
    accept      = in_valid && cfg_enable && (!is_full || commit_word);
    drop        = in_valid && cfg_enable && is_full && !commit_word;
    eop_now     = (beat_q == LAST_BEAT) || timeout || acc_eop_q;

    state_n    = state_q;
    acc_cnt_n  = acc_cnt_q;
    acc_data_n = acc_data_q;
    acc_eop_n  = acc_eop_q;
    beat_n     = beat_q;
    word_n     = word_q;
    valid_n    = valid_q;
    dest_n     = dest_q;
    ovf_n      = ovf_q;

    if (commit_word) begin
      state_n    = EMPTY;
      acc_cnt_n  = 3'd0;
      acc_data_n = '0;
      acc_eop_n  = 1'b0;
    end

    if (accept) begin
      acc_data_n = acc_data_n | ({24'b0, in_byte} << {acc_cnt_n[1:0], 3'b000});
      acc_cnt_n  = acc_cnt_n + 3'd1;
      acc_eop_n  = delim_hit;
      state_n    = ((acc_cnt_n == 3'd4) || delim_hit) ? FULL : FILL;
    end

    if (commit_word || commit_term) begin
      valid_n       = 1'b1;
      word_n.data   = commit_word ? acc_data_q : '0;
      word_n.nbytes = commit_word ? acc_cnt_q : 3'd0;
      word_n.eop    = eop_now;
      if (beat_q == '0) begin
        dest_n = cfg_dest;
      end
      beat_n = eop_now ? '0 : beat_q + 1'b1;
    end else if (mbx.out_ready) begin
      valid_n = 1'b0;
    end

    if (drop && (ovf_q != 16'hFFFF)) begin
      ovf_n = ovf_q + 16'd1;
    end
  end

  // State register; reset discards any partial word or message.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      acc_cnt_q  <= 3'd0;
      acc_data_q <= '0;
      acc_eop_q  <= 1'b0;
      beat_q     <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      dest_q     <= DEFAULT_DEST;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_n;
      acc_cnt_q  <= acc_cnt_n;
      acc_data_q <= acc_data_n;
      acc_eop_q  <= acc_eop_n;
      beat_q     <= beat_n;
      word_q     <= word_n;
      valid_q    <= valid_n;
      dest_q     <= dest_n;
      ovf_q      <= ovf_n;
    end
  end

  assign in_ready        = !rst && !(cfg_enable && is_full && !reg_free);
  assign ovf_cnt         = ovf_q;
  assign mbx.out_valid   = valid_q;
  assign mbx.out_data    = word_q.data;
  assign mbx.out_nbytes  = word_q.nbytes;
  assign mbx.out_eop     = word_q.eop;
  assign mbx.out_dest_id = dest_q;
  assign mbx.out_opcode  = OPC_DATA;
  assign mbx.out_prio    = 1'b0;

endmodule
